// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} sipo_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// Single-entry valid/ready holding register for completed words.
module sipo_out_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  drop
);

  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_valid;

  // A new word is lost only when the held word is not leaving this cycle.
  assign drop = load && r_valid && !dout_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (load && (!r_valid || dout_ready)) begin
      r_dout  <= load_data;
      r_valid <= 1'b1;
    end else if (r_valid && dout_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial-to-parallel receiver with start alignment, framing-error
// and overrun reporting; completed words leave through sipo_out_stage.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_valid,
  input  logic                  din_start,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int             CW   = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

  sipo_state_t           r_state, w_next_state;
  logic [CW-1:0]         r_bit_cnt, w_bit_cnt_next;
  logic [DATA_WIDTH-1:0] r_sh, w_sh_next, w_word;
  logic                  w_start, w_take, w_resync, w_complete, w_drop;
  logic                  r_overrun, r_frame_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_sh        <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_bit_cnt   <= w_bit_cnt_next;
      r_sh        <= w_sh_next;
      r_overrun   <= w_drop;
      r_frame_err <= w_resync;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_sh_next      = r_sh;
    w_resync       = 1'b0;
    w_complete     = 1'b0;
    w_start        = din_valid && din_start;
    // In IDLE only a start bit is accepted; in RUN every valid bit is.
    w_take         = din_valid && ((r_state == RUN) || din_start);
    w_word         = {din, r_sh[DATA_WIDTH-1:1]};

    if (r_state == IDLE && w_start) begin
      w_next_state = RUN;
    end

    if (w_take) begin
      w_sh_next = w_word;
      if (w_start) begin
        // A start always wins, even on the last bit: the partial word is abandoned.
        w_bit_cnt_next = CW'(1);
        w_resync       = (r_bit_cnt != '0);
      end else if (r_bit_cnt == LAST) begin
        w_bit_cnt_next = '0;
        w_complete     = 1'b1;
      end else begin
        w_bit_cnt_next = r_bit_cnt + 1'b1;
      end
    end
  end

  sipo_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk        (clk),
    .resetn     (resetn),
    .load       (w_complete),
    .load_data  (w_word),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .drop       (w_drop)
  );

  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign busy      = (r_bit_cnt != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer at DATA_WIDTH=16.
module tb_sipo_deserializer;

  logic        clk;
  logic        resetn;
  logic        din;
  logic        din_valid;
  logic        din_start;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;
  logic        frame_err;
  logic        busy;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_vld  = 0;
  int          n_ovr  = 0;
  int          n_fe   = 0;
  logic [15:0] q_acc[$];

  int          b_vld, b_ovr, b_fe, b_q;

  sipo_deserializer #(.DATA_WIDTH(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_start  (din_start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs sampled mid-cycle; inputs only change 1 ns after the rising edge.
  always @(negedge clk) begin
    if (dout_valid) n_vld++;
    if (dout_valid && dout_ready) begin
      q_acc.push_back(dout);
      $display("[%0t] accepted dout=%h", $time, dout);
    end
    if (overrun)   n_ovr++;
    if (frame_err) n_fe++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input logic v, input logic s, input logic b);
    @(posedge clk);
    #1;
    din_valid = v;
    din_start = s;
    din       = b;
  endtask

  task automatic mark();
    b_vld = n_vld;
    b_ovr = n_ovr;
    b_fe  = n_fe;
    b_q   = q_acc.size();
  endtask

  task automatic send_word(input logic [15:0] w, input logic start, input int maxgap);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, maxgap)) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, start && (i == 0), w[i]);
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [4:0]  partial;
    resetn = 1'b0; din = 1'b0; din_valid = 1'b0; din_start = 1'b0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 16'h0000);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    resetn = 1'b1;

    // Unsynchronised bits in IDLE are ignored.
    mark();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_valid", dout_valid, 1'b0);
    check("idle_words", q_acc.size() - b_q, 0);

    // Single aligned word, 1-cycle latency, valid for one cycle.
    mark();
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) cyc(1'b1, i == 0, w[i]);
    check("t1_pre_valid", dout_valid, 1'b0);
    check("t1_pre_busy", busy, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t1_valid", dout_valid, 1'b1);
    check("t1_dout", dout, 16'hA5C3);
    check("t1_busy", busy, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t1_valid_fall", dout_valid, 1'b0);
    check("t1_vld_cycles", n_vld - b_vld, 1);
    check("t1_words", q_acc.size() - b_q, 1);

    // Back-to-back words with gaps; din_start held during gaps must be ignored.
    mark();
    send_word(16'h1234, 1'b1, 2);
    send_word(16'hBEEF, 1'b0, 2);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("t2_words", q_acc.size() - b_q, 2);
    if (q_acc.size() - b_q == 2) begin
      check("t2_w0", q_acc[b_q], 16'h1234);
      check("t2_w1", q_acc[b_q+1], 16'hBEEF);
    end
    check("t2_overrun", n_ovr - b_ovr, 0);
    check("t2_frame_err", n_fe - b_fe, 0);

    // Overrun: second word dropped while the first is held.
    mark();
    dout_ready = 1'b0;
    send_word(16'h0001, 1'b0, 0);
    send_word(16'hFFFF, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t3_overrun_pulse", overrun, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t3_overrun_clear", overrun, 1'b0);
    check("t3_hold_valid", dout_valid, 1'b1);
    check("t3_hold_dout", dout, 16'h0001);
    check("t3_overrun_cnt", n_ovr - b_ovr, 1);
    cyc(1'b0, 1'b0, 1'b0);
    dout_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("t3_valid_fall", dout_valid, 1'b0);
    check("t3_words", q_acc.size() - b_q, 1);
    if (q_acc.size() - b_q == 1) check("t3_w0", q_acc[b_q], 16'h0001);

    // Resync after a 5-bit partial word.
    mark();
    partial = 5'b10110;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, partial[i]);
    cyc(1'b0, 1'b0, 1'b0);
    check("t4_busy", busy, 1'b1);
    send_word(16'h5A5A, 1'b1, 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("t4_frame_err_cnt", n_fe - b_fe, 1);
    check("t4_words", q_acc.size() - b_q, 1);
    if (q_acc.size() - b_q == 1) check("t4_w0", q_acc[b_q], 16'h5A5A);

    // Start on the last bit position: resync, no completion.
    mark();
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b1);
    w = 16'h8001;
    for (int i = 0; i < 16; i++) cyc(1'b1, i == 0, w[i]);
    cyc(1'b0, 1'b0, 1'b0);
    check("t7_valid", dout_valid, 1'b1);
    check("t7_dout", dout, 16'h8001);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check("t7_frame_err_cnt", n_fe - b_fe, 1);
    check("t7_words", q_acc.size() - b_q, 1);

    // Reset mid-word, then unaligned bits must be ignored.
    mark();
    w = 16'h0F0F;
    for (int i = 0; i < 9; i++) cyc(1'b1, i == 0, w[i]);
    cyc(1'b0, 1'b0, 1'b0);
    check("t5_busy_pre", busy, 1'b1);
    resetn = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    check("t5_busy_rst", busy, 1'b0);
    send_word(16'hFFFF, 1'b0, 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_valid_cnt", n_vld - b_vld, 0);
    send_word(16'hC001, 1'b1, 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t5_dout", dout, 16'hC001);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check("t5_words", q_acc.size() - b_q, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
